// File: rtl/assert_collect_pkg.sv
// Shared types and defaults for the assertion event collector and its FIFO.
package assert_collect_pkg;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned DEF_TS_W    = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_DROP_W  = 8;

    // Widest source index (32 sources) and widest supported timestamp.
    localparam int unsigned SRC_MAX_W = 5;
    localparam int unsigned TS_MAX_W  = 64;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [SRC_MAX_W-1:0] src;
        logic                 multi;
        logic [TS_MAX_W-1:0]  ts;
    } evt_t;

    function automatic logic [SRC_MAX_W-1:0] lowest_set(input logic [31:0] v);
        logic [SRC_MAX_W-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i] && !found) begin
                idx   = SRC_MAX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/assert_evt_fifo.sv
// Synchronous FIFO with push/pop/flush; DEPTH must be a power of two.
module assert_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/assert_event_collector.sv
// Edge-detects assertion failures into timestamped events, queues them for a host, raises halt.
// Optional macro ASSERT_COLLECT_PRINT_EN: simulation-only push/drop messages.
module assert_event_collector
  import assert_collect_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned TS_W    = DEF_TS_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned DROP_W  = DEF_DROP_W,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_ok,
  input  logic               chk_en,
  input  logic               stop_on_fail,
  input  logic               clear,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [SRC_W-1:0]   evt_src,
  output logic               evt_multi,
  output logic [TS_W-1:0]    evt_ts,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               halt_req
);

  localparam int unsigned FW = SRC_W + 1 + TS_W;

  logic [TS_W-1:0]    ts_cnt;
  logic [NUM_SRC-1:0] fail_vec;
  logic [NUM_SRC-1:0] fail_hist;
  logic [NUM_SRC-1:0] new_vec;
  logic [31:0]        new_wide;
  state_e             state;
  evt_t               evt;
  logic               evt_any;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               empty;
  logic [FW-1:0]      fifo_din;
  logic [FW-1:0]      fifo_dout;

  assign fail_vec = chk_en ? ~src_ok : '0;
  assign new_vec  = fail_vec & ~fail_hist;
  assign new_wide = 32'(new_vec);
  assign evt_any  = |new_vec;

  always_comb begin
    evt       = '0;
    evt.src   = lowest_set(new_wide);
    evt.multi = more_than_one(new_wide);
    evt.ts    = TS_MAX_W'(ts_cnt);
  end

  assign fifo_din = {SRC_W'(evt.src), evt.multi, TS_W'(evt.ts)};

  // Clear discards a coincident event outright: neither pushed nor counted.
  assign pop  = evt_valid & evt_ready;
  assign push = evt_any & ~clear & (state == RUN) & (~full | pop);
  assign drop = evt_any & ~clear & ((state == HALT) | (full & ~pop));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ts_cnt    <= '0;
      fail_hist <= '0;
    end else begin
      ts_cnt    <= ts_cnt + TS_W'(1);
      fail_hist <= fail_vec;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state <= RUN;
    end else if (state == RUN && stop_on_fail && (push || drop)) begin
      state <= HALT;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assert_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty)
  );

  assign evt_valid                    = ~empty;
  assign {evt_src, evt_multi, evt_ts} = empty ? '0 : fifo_dout;
  assign halt_req                     = (state == HALT);

`ifdef ASSERT_COLLECT_PRINT_EN
`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n && push)
      $display("assert_event_collector: event src=%0d multi=%0d ts=%0d",
               SRC_W'(evt.src), evt.multi, ts_cnt);
    if (reset_n && drop)
      $display("assert_event_collector: event dropped, drop_cnt before=%0d",
               drop_cnt);
  end
`endif
`endif

endmodule

// File: tb/tb_assert_event_collector.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_assert_event_collector;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  src_ok;
    logic        chk_en;
    logic        stop_on_fail;
    logic        clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_src;
    logic        evt_multi;
    logic [31:0] evt_ts;
    logic [7:0]  drop_cnt;
    logic        halt_req;

    typedef struct {
        int unsigned src;
        bit          multi;
        logic [31:0] ts;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned valid_cycles = 0;
    logic [31:0] ts_m = '0;

    assert_event_collector #(
        .NUM_SRC (4),
        .TS_W    (32),
        .DEPTH   (4),
        .DROP_W  (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .src_ok       (src_ok),
        .chk_en       (chk_en),
        .stop_on_fail (stop_on_fail),
        .clear        (clear),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_src      (evt_src),
        .evt_multi    (evt_multi),
        .evt_ts       (evt_ts),
        .drop_cnt     (drop_cnt),
        .halt_req     (halt_req)
    );

    always #5 clock = ~clock;

    // Reference cycle counter: zero while in reset, +1 every cycle otherwise.
    always @(posedge clock) ts_m <= reset_n ? ts_m + 32'd1 : 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic push_exp(input int unsigned s, input bit m, input logic [31:0] t);
        exp_t e;
        e.src   = s;
        e.multi = m;
        e.ts    = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Monitor: compares each accepted head against the scoreboard.
    always @(negedge clock) begin
        if (evt_valid) valid_cycles++;
        if (reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_evt: got src=%0d multi=%0d ts=%0d, expected no event",
                         evt_src, evt_multi, evt_ts);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_src",   64'(evt_src),   64'(e.src));
                chk("evt_multi", 64'(evt_multi), 64'(e.multi));
                chk("evt_ts",    64'(evt_ts),    64'(e.ts));
            end
        end
        if (reset_n && !evt_valid)
            chk("idle_outputs_zero", 64'({evt_src, evt_multi, evt_ts}), 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned guard;
        reset_n      = 1'b0;
        src_ok       = '1;
        chk_en       = 1'b1;
        stop_on_fail = 1'b0;
        clear        = 1'b0;
        evt_ready    = 1'b0;

        step();
        step();
        at_neg();
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);
        chk("rst_halt",  64'(halt_req),  64'd0);
        chk("rst_ts",    64'(evt_ts),    64'd0);
        step();
        reset_n = 1'b1;

        // Single failure held for 5 cycles starting at ts=10.
        evt_ready    = 1'b1;
        valid_cycles = 0;
        guard        = 0;
        while (ts_m != 32'd10 && guard < 100) begin
            step();
            guard++;
        end
        src_ok[2] = 1'b0;
        push_exp(2, 1'b0, 32'd10);
        repeat (5) step();
        src_ok = '1;
        wait_drain(20);
        chk("single_valid_cycles", 64'(valid_cycles), 64'd1);

        // Sources 1 and 3 fail together.
        src_ok = 4'b0101;
        push_exp(1, 1'b1, ts_m);
        step();
        src_ok = '1;
        wait_drain(20);

        // Overflow: six edges with the host stalled.
        evt_ready = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            src_ok = '1;
            src_ok[i % 4] = 1'b0;
            if (i < 4) push_exp(i % 4, 1'b0, ts_m);
            step();
        end
        src_ok = '1;
        at_neg();
        chk("ovf_valid", 64'(evt_valid), 64'd1);
        chk("ovf_drop",  64'(drop_cnt),  64'd2);
        chk("ovf_halt",  64'(halt_req),  64'd0);
        chk("ovf_head",  64'(evt_src),   64'd0);
        step();
        evt_ready = 1'b1;
        wait_drain(20);
        at_neg();
        chk("ovf_empty", 64'(evt_valid), 64'd0);
        chk("ovf_drop_kept", 64'(drop_cnt), 64'd2);

        // Halt on first failure, drops in HALT, clear beating a coincident edge.
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        at_neg();
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        step();
        stop_on_fail = 1'b1;
        src_ok = 4'b1110;
        push_exp(0, 1'b0, ts_m);
        step();
        src_ok = 4'b1101;
        at_neg();
        chk("halt_set", 64'(halt_req), 64'd1);
        step();
        src_ok = 4'b1011;
        step();
        src_ok = 4'b0111;
        step();
        src_ok = 4'b1110;
        clear  = 1'b1;
        at_neg();
        chk("halt_drop", 64'(drop_cnt), 64'd3);
        chk("halt_held", 64'(halt_req), 64'd1);
        step();
        clear        = 1'b0;
        src_ok       = '1;
        stop_on_fail = 1'b0;
        at_neg();
        chk("clr_halt",  64'(halt_req),  64'd0);
        chk("clr_drop2", 64'(drop_cnt),  64'd0);
        chk("clr_valid", 64'(evt_valid), 64'd0);
        chk("clr_queue", 64'(exp_q.size()), 64'd0);

        // Checking disabled while all sources fail, then enabled.
        step();
        valid_cycles = 0;
        chk_en = 1'b0;
        src_ok = '0;
        repeat (10) step();
        at_neg();
        chk("masked_no_evt", 64'(valid_cycles), 64'd0);
        step();
        chk_en = 1'b1;
        push_exp(0, 1'b1, ts_m);
        step();
        step();
        src_ok = '1;
        wait_drain(20);
        chk("enable_one_evt", 64'(valid_cycles), 64'd1);

        // Reset with three queued events; counter restarts at zero.
        evt_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            src_ok = '1;
            src_ok[i] = 1'b0;
            step();
        end
        src_ok = '1;
        at_neg();
        chk("pre_rst_valid", 64'(evt_valid), 64'd1);
        step();
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        src_ok[3] = 1'b0;
        push_exp(3, 1'b0, 32'd0);
        at_neg();
        chk("mid_rst_valid", 64'(evt_valid), 64'd0);
        chk("mid_rst_drop",  64'(drop_cnt),  64'd0);
        step();
        src_ok    = '1;
        evt_ready = 1'b1;
        wait_drain(20);

        repeat (3) step();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
